// File: rtl/muldiv_pkg.sv
// muldiv_pkg: op encodings, FSM states and default width for the multiply/divide unit.
package muldiv_pkg;
  localparam int WIDTH_DEF = 32;
  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;
  typedef enum logic [1:0] {IDLE, CALC, FIXUP, DONE} state_e;
endpackage

// File: rtl/muldiv_step.sv
// muldiv_step: one combinational iteration, shift-add multiply or restoring divide.
// acc holds {upper, lower}: product/multiplier for multiply, remainder/quotient for divide.
module muldiv_step import muldiv_pkg::*; #(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic               div,
  input  logic [2*WIDTH-1:0] acc,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] acc_next
);
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   shl;
  logic [WIDTH+1:0] diff;
  always_comb begin
    sum      = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, b} : '0);
    shl      = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    diff     = {1'b0, shl} - {2'b0, b};
    acc_next = div ? {diff[WIDTH+1] ? shl[WIDTH-1:0] : diff[WIDTH-1:0], acc[WIDTH-2:0], ~diff[WIDTH+1]}
                   : {sum, acc[WIDTH-1:1]};
  end
endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative MULT/MULTU/DIV/DIVU with HI/LO registers and pipeline stall request.
// Divide support is built only when MULDIV_DIV_EN is defined.
module muldiv_unit import muldiv_pkg::*; #(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  input  logic             hilo_rd,
  input  logic             mthi_we,
  input  logic             mtlo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             stall,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
`ifdef MULDIV_DIV_EN
  localparam logic DIV_EN = 1'b1;
`else
  localparam logic DIV_EN = 1'b0;
`endif
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d, step_acc, prod;
  logic [WIDTH-1:0]   b_q, b_d, hi_q, hi_d, lo_q, lo_d;
  logic [WIDTH-1:0]   rs_mag, rt_mag, quo, rem;
  logic               div_q, div_d, neg_res_q, neg_res_d, neg_rem_q, neg_rem_d, dz_q, dz_d;
  logic               sgn, accept, commit;

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .div      (div_q),
    .acc      (acc_q),
    .b        (b_q),
    .acc_next (step_acc)
  );

  assign busy  = (state_q == CALC) | (state_q == FIXUP);
  assign done  = state_q == DONE;
  assign stall = busy & (hilo_rd | mthi_we | mtlo_we | start);
  assign hi    = hi_q;
  assign lo    = lo_q;

  always_comb begin
    sgn       = ~op[0];
    rs_mag    = (sgn & rs_val[WIDTH-1]) ? -rs_val : rs_val;
    rt_mag    = (sgn & rt_val[WIDTH-1]) ? -rt_val : rt_val;
    accept    = start & ((state_q == IDLE) | (state_q == DONE)) & (DIV_EN | ~op[1]);
    commit    = state_q == FIXUP;
    prod      = neg_res_q ? -acc_q : acc_q;
    quo       = dz_q ? '1 : neg_res_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    rem       = neg_rem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    b_d       = b_q;
    div_d     = div_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    dz_d      = dz_q;
    if (accept) begin
      state_d   = CALC;
      cnt_d     = '0;
      acc_d     = {{WIDTH{1'b0}}, op[1] ? rs_mag : rt_mag};
      b_d       = op[1] ? rt_mag : rs_mag;
      div_d     = op[1] & DIV_EN;
      neg_res_d = sgn & (rs_val[WIDTH-1] ^ rt_val[WIDTH-1]);
      neg_rem_d = sgn & rs_val[WIDTH-1];
      dz_d      = op[1] & ~|rt_val;
    end else if (state_q == CALC) begin
      acc_d   = step_acc;
      cnt_d   = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
      state_d = (cnt_q == LAST) ? FIXUP : CALC;
    end else if (state_q == FIXUP) begin
      state_d = DONE;
    end else if (state_q == DONE) begin
      state_d = IDLE;
    end
    // a result commit always beats a concurrent MTHI/MTLO write
    hi_d = commit ? (div_q ? rem : prod[2*WIDTH-1:WIDTH]) : (mthi_we & ~busy) ? wdata : hi_q;
    lo_d = commit ? (div_q ? quo : prod[WIDTH-1:0]) : (mtlo_we & ~busy) ? wdata : lo_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      b_q       <= '0;
      div_q     <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      dz_q      <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      b_q       <= b_d;
      div_q     <= div_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      dz_q      <= dz_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: randomized and directed checks of muldiv_unit against an arithmetic reference model.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n, start, hilo_rd, mthi_we, mtlo_we;
  logic [1:0]  op;
  logic [31:0] rs_val, rt_val, wdata, hi, lo;
  logic        busy, done, stall;
  int          checks = 0, failures = 0;
  logic [31:0] m_hi = '0, m_lo = '0;

  always #5 clk = ~clk;

  muldiv_unit dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .rs_val(rs_val), .rt_val(rt_val),
    .hilo_rd(hilo_rd), .mthi_we(mthi_we), .mtlo_we(mtlo_we), .wdata(wdata),
    .busy(busy), .done(done), .stall(stall), .hi(hi), .lo(lo)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] ref_model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ua, ub, q, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'b0, a});
    ub = longint'({32'b0, b});
    if (o[1] && b == 0) return {a, 32'hFFFF_FFFF};
    if (o == OP_MULT) return sa * sb;
    if (o == OP_MULTU) return ua * ub;
    q = o[0] ? ua / ub : sa / sb;
    r = o[0] ? ua % ub : sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b, input bit intr);
    logic [63:0] e;
    logic [31:0] lo0;
    int bc, dk, dc;
    e = ref_model(o, a, b);
    lo0 = lo;
    bc = 0; dk = 0; dc = 0;
    @(negedge clk);
    start = 1; op = o; rs_val = a; rt_val = b;
    @(posedge clk);
    #1 start = 0; rs_val = $urandom; rt_val = $urandom;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (intr && k == 5) begin
        start = 1; op = OP_MULTU; mtlo_we = 1; wdata = 32'hDEAD_BEEF;
        #1 check("stall_mid_op", stall, 1);
      end
      if (intr && k == 6) begin
        start = 0; mtlo_we = 0;
        check("lo_hold_busy", lo, lo0);
      end
      bc += busy;
      dc += done;
      if (done && dk == 0) dk = k;
    end
    check("busy_cycles", bc, 33);
    check("done_latency", dk, 34);
    check("done_pulses", dc, 1);
    check("hi", hi, e[63:32]);
    check("lo", lo, e[31:0]);
    m_hi = e[63:32];
    m_lo = e[31:0];
  endtask

  task automatic mt_write(input bit to_hi, input logic [31:0] d);
    @(negedge clk);
    mthi_we = to_hi; mtlo_we = ~to_hi; wdata = d;
    @(posedge clk);
    #1 mthi_we = 0; mtlo_we = 0;
    if (to_hi) begin check("mthi", hi, d); m_hi = d; end
    else begin check("mtlo", lo, d); m_lo = d; end
  endtask

  task automatic run_ignored(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    int bc, dc;
    bc = 0; dc = 0;
    @(negedge clk);
    start = 1; op = o; rs_val = a; rt_val = b;
    @(posedge clk);
    #1 start = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      bc += busy;
      dc += done;
    end
    check("nodiv_busy", bc, 0);
    check("nodiv_done", dc, 0);
    check("nodiv_hi", hi, m_hi);
    check("nodiv_lo", lo, m_lo);
  endtask

  initial begin
    logic [63:0] ea, eb;
    int dc;
    logic [1:0] ro;
    rst_n = 0; start = 0; op = '0; rs_val = '0; rt_val = '0;
    hilo_rd = 0; mthi_we = 0; mtlo_we = 0; wdata = '0;
    repeat (2) @(negedge clk);
    check("rst_hi", hi, 0);
    check("rst_lo", lo, 0);
    check("rst_flags", {busy, done, stall}, 0);
    rst_n = 1;
    @(negedge clk);
    check("idle_flags", {busy, done, stall}, 0);

    run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    check("multu_max", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
    run_op(OP_MULT, -32'sd3, 32'd7, 1);
    check("mult_neg", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFEB);

    mt_write(1, 32'h1234);
    mt_write(0, 32'h5678);

    // start together with MTHI in IDLE: HI takes wdata now, result later
    ea = ref_model(OP_MULTU, 32'd1000, 32'd3000);
    @(negedge clk);
    start = 1; op = OP_MULTU; rs_val = 32'd1000; rt_val = 32'd3000; mthi_we = 1; wdata = 32'h55;
    @(posedge clk);
    #1 start = 0; mthi_we = 0;
    check("start_mthi_now", hi, 32'h55);
    repeat (40) @(negedge clk);
    check("start_mthi_res", {hi, lo}, ea);
    m_hi = ea[63:32]; m_lo = ea[31:0];

    // back-to-back: start held through DONE
    ea = ref_model(OP_MULTU, 32'hDEAD_0001, 32'h0000_BEEF);
    eb = ref_model(OP_MULT, 32'h8000_0000, 32'h7FFF_FFFF);
    @(negedge clk);
    start = 1; op = OP_MULTU; rs_val = 32'hDEAD_0001; rt_val = 32'h0000_BEEF;
    @(posedge clk);
    for (int k = 1; k <= 70; k++) begin
      @(negedge clk);
      if (k == 1) begin op = OP_MULT; rs_val = 32'h8000_0000; rt_val = 32'h7FFF_FFFF; end
      if (k == 34) begin check("b2b_done1", done, 1); check("b2b_res1", {hi, lo}, ea); end
      if (k == 35) start = 0;
      if (k == 68) begin check("b2b_done2", done, 1); check("b2b_res2", {hi, lo}, eb); end
    end
    m_hi = eb[63:32]; m_lo = eb[31:0];

    // reset mid-operation
    @(negedge clk);
    start = 1; op = OP_MULT; rs_val = 32'd5; rt_val = 32'd6;
    @(posedge clk);
    #1 start = 0;
    repeat (9) @(negedge clk);
    rst_n = 0;
    #1 check("midrst_hilo", {hi, lo}, 0);
    check("midrst_flags", {busy, done}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1;
    m_hi = '0; m_lo = '0;
    dc = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      dc += done;
    end
    check("midrst_no_done", dc, 0);
    check("midrst_idle", busy, 0);
    run_op(OP_MULT, 32'd123456, -32'sd789, 0);

`ifdef MULDIV_DIV_EN
    run_op(OP_DIV, -32'sd7, 32'd2, 0);
    check("div_neg", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
    run_op(OP_DIVU, 32'd100, 32'd0, 0);
    check("divu_zero", {hi, lo}, {32'd100, 32'hFFFF_FFFF});
    run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    check("div_ovf", {hi, lo}, {32'h0, 32'h8000_0000});
    run_op(OP_DIV, -32'sd9, 32'd0, 0);
    for (int i = 0; i < 24; i++) begin
      ro = 2'($urandom_range(0, 3));
      run_op(ro, $urandom, (i % 6 == 5) ? 32'($urandom_range(0, 15)) : $urandom, 0);
    end
`else
    run_ignored(OP_DIV, 32'd9, 32'd3);
    run_ignored(OP_DIVU, $urandom, $urandom);
    for (int i = 0; i < 20; i++) begin
      ro = 2'($urandom_range(0, 1));
      run_op(ro, $urandom, (i % 5 == 4) ? 32'($urandom_range(0, 15)) : $urandom, 0);
    end
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
